// File: rtl/vedic_seq_pkg.sv
// rtl/vedic_seq_pkg.sv - shared state encoding, step count and shift table for vedic_16x16_seq
package vedic_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int NSTEPS = 4;

  localparam logic [4:0] SHIFT_S0 = 5'd0;
  localparam logic [4:0] SHIFT_S1 = 5'd8;
  localparam logic [4:0] SHIFT_S2 = 5'd8;
  localparam logic [4:0] SHIFT_S3 = 5'd16;

  function automatic logic [4:0] step_shift(input logic [1:0] step);
    case (step)
      2'd0:    step_shift = SHIFT_S0;
      2'd1:    step_shift = SHIFT_S1;
      2'd2:    step_shift = SHIFT_S2;
      default: step_shift = SHIFT_S3;
    endcase
  endfunction

endpackage

// File: rtl/vedic_8x8.sv
// rtl/vedic_8x8.sv - combinational 8x8 unsigned multiplier from four 4x4 vertical/crosswise products
module vedic_8x8 (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);

  logic [7:0] w_ll, w_hl, w_lh, w_hh;

  assign w_ll = {4'd0, i_a[3:0]} * {4'd0, i_b[3:0]};
  assign w_hl = {4'd0, i_a[7:4]} * {4'd0, i_b[3:0]};
  assign w_lh = {4'd0, i_a[3:0]} * {4'd0, i_b[7:4]};
  assign w_hh = {4'd0, i_a[7:4]} * {4'd0, i_b[7:4]};

  assign o_p = {8'd0, w_ll} + {4'd0, w_hl, 4'd0} + {4'd0, w_lh, 4'd0} + {w_hh, 8'd0};

endmodule

// File: rtl/vedic_16x16_seq.sv
// rtl/vedic_16x16_seq.sv - sequential 16x16 multiplier sharing one vedic_8x8; optional VEDIC_SEQ_ZERO_SKIP_EN
module vedic_16x16_seq
  import vedic_seq_pkg::*;
#(
  parameter int PIPE_PP = 0,
  parameter int ACC_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] c,
  output logic             busy
);

  localparam logic [2:0] LAST = 3'(NSTEPS - 1 + PIPE_PP);

  state_t           r_state;
  logic [15:0]      r_a, r_b;
  logic [ACC_W-1:0] r_acc;
  logic [2:0]       r_cnt;
  logic             r_in_ready, r_out_valid, r_busy;

  logic [1:0]       w_step;
  logic [7:0]       w_x, w_y;
  logic [15:0]      w_pp, w_add_pp;
  logic [1:0]       w_add_step;
  logic             w_add_en;
  logic [ACC_W-1:0] w_addend;
  logic             w_skip;

  // step bit 0 picks the high byte of a, step bit 1 the high byte of b
  assign w_step = r_cnt[1:0];
  assign w_x    = w_step[0] ? r_a[15:8] : r_a[7:0];
  assign w_y    = w_step[1] ? r_b[15:8] : r_b[7:0];

  vedic_8x8 u_pp (
    .i_a (w_x),
    .i_b (w_y),
    .o_p (w_pp)
  );

  generate
    if (PIPE_PP != 0) begin : g_pipe
      logic [15:0] r_pp;
      logic [1:0]  r_pp_step;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pp      <= '0;
          r_pp_step <= '0;
        end else begin
          r_pp      <= w_pp;
          r_pp_step <= w_step;
        end
      end
      // first MUL cycle only fills the product register
      assign w_add_pp   = r_pp;
      assign w_add_step = r_pp_step;
      assign w_add_en   = (r_cnt != 3'd0);
    end else begin : g_comb
      assign w_add_pp   = w_pp;
      assign w_add_step = w_step;
      assign w_add_en   = 1'b1;
    end
  endgenerate

  assign w_addend = ACC_W'({16'd0, w_add_pp}) << step_shift(w_add_step);

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
  assign w_skip = (a == 16'd0) || (b == 16'd0);
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            if (w_skip) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_MUL;
              r_busy  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_add_en) r_acc <= r_acc + w_addend;
          if (r_cnt == LAST) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign c         = r_acc;

endmodule

// File: tb/tb_vedic_16x16_seq.sv
// tb/tb_vedic_16x16_seq.sv - randomized self-checking bench for vedic_16x16_seq against a plain a*b model
module tb_vedic_16x16_seq;

  localparam int PIPE_PP = 0;
  localparam int LAT_MUL = 5 + PIPE_PP;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  vedic_16x16_seq #(.PIPE_PP(PIPE_PP), .ACC_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [15:0] xa, input logic [15:0] xb);
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
    if (xa == 16'd0 || xb == 16'd0) return 1;
`endif
    return LAT_MUL;
  endfunction

  // present one operand pair, return cycles from accept edge to first out_valid
  task automatic do_job(input logic [15:0] xa, input logic [15:0] xb,
                        output int lat, output logic busy_seen);
    int guard;
    in_valid = 1'b1;
    a = xa;
    b = xb;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check_eq("accept_timeout", 32'(guard), 32'd0);
    tick();
    in_valid = 1'b0;
    lat = 1;
    busy_seen = busy;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
      busy_seen |= busy;
    end
  endtask

  task automatic job_check(input string tag, input logic [15:0] xa, input logic [15:0] xb);
    int       lat;
    logic     bs;
    out_ready = 1'b1;
    do_job(xa, xb, lat, bs);
    check_eq({tag, "_c"}, c, 32'(xa) * 32'(xb));
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat(xa, xb)));
    check_eq({tag, "_busy_seen"}, 32'(bs), (exp_lat(xa, xb) == 1) ? 32'd0 : 32'd1);
    tick();
    check_eq({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  logic [31:0] exp_q[$];

  initial begin
    int          lat;
    logic        bs;
    int          sent, got, cycles;
    logic [15:0] na, nb;
    logic [31:0] exp_c;
    logic        fire_in, fire_out;
    logic        saw_ov;

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_c", c, 32'd0);

    job_check("basic", 16'h1234, 16'h5678);
    check_eq("basic_const", 32'h1234 * 32'h5678, 32'h06260060);
    job_check("max", 16'hFFFF, 16'hFFFF);
    job_check("one_max", 16'h0001, 16'hFFFF);
    job_check("zero", 16'h0000, 16'hBEEF);

    // backpressure: hold the result for three cycles while in_valid pulses
    out_ready = 1'b0;
    do_job(16'h00FF, 16'h0100, lat, bs);
    check_eq("bp_lat", 32'(lat), 32'(LAT_MUL));
    check_eq("bp_c", c, 32'h0000FF00);
    for (int i = 0; i < 3; i++) begin
      in_valid = (i != 1);
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
      check_eq("bp_hold_c", c, 32'h0000FF00);
      check_eq("bp_hold_ov", 32'(out_valid), 32'd1);
      check_eq("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("bp_release_in_ready", 32'(in_ready), 32'd1);
    check_eq("bp_release_ov", 32'(out_valid), 32'd0);

    // reset while step 2 is being processed
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 16'hABCD;
    b = 16'h1111;
    tick();
    in_valid = 1'b0;
    saw_ov = out_valid;
    tick();
    saw_ov |= out_valid;
    tick();
    saw_ov |= out_valid;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rstmid_in_ready", 32'(in_ready), 32'd1);
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    check_eq("rstmid_c", c, 32'd0);
    for (int i = 0; i < 8; i++) begin
      saw_ov |= out_valid;
      tick();
    end
    check_eq("rstmid_no_result", 32'(saw_ov), 32'd0);
    job_check("after_rst", 16'd3, 16'd5);

    // streaming: in_valid held high, random out_ready, in-order scoreboard
    sent = 0;
    got = 0;
    cycles = 0;
    na = 16'($urandom);
    nb = 16'($urandom);
    while (got < 100 && cycles < 20000) begin
      in_valid = (sent < 100);
      a = na;
      b = nb;
      out_ready = 1'($urandom);
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        if (exp_q.size() == 0) begin
          check_eq("stream_unexpected", c, 32'hDEADBEEF);
        end else begin
          exp_c = exp_q.pop_front();
          check_eq("stream_c", c, exp_c);
        end
        got++;
      end
      if (fire_in) begin
        exp_q.push_back(32'(na) * 32'(nb));
        sent++;
        case ($urandom_range(0, 7))
          0:       begin na = 16'h0000; nb = 16'($urandom); end
          1:       begin na = 16'hFFFF; nb = 16'hFFFF; end
          default: begin na = 16'($urandom); nb = 16'($urandom); end
        endcase
      end
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    check_eq("stream_count", 32'(got), 32'd100);
    check_eq("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
